bias_block_loader: RTL and testbench

BIAS_BLOCK_LOADER -- requirements
Module: bias_block_loader

---
 rtl/bias_block_loader_if.sv | 28 ++
 rtl/bias_block_loader.sv | 104 ++++++++++
 tb/tb_bias_block_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_block_loader_if.sv
// rtl/bias_block_loader_if.sv - load request, bias memory read port and block result bundle
interface bias_block_loader_if #(
   parameter int DATA_SZ   = 16,
   parameter int ADDR_SZ   = 16,
   parameter int BLOCK_LEN = 25
);
   logic                      loadEnable;
   logic [ADDR_SZ-1:0]        loadAddr;
   logic [4:0]                loadLen;
   logic                      memReadEnable;
   logic [ADDR_SZ-1:0]        memReadAddr;
   logic signed [DATA_SZ-1:0] memReadData;
   logic signed [DATA_SZ-1:0] loadedBiases [BLOCK_LEN];
   logic                      loadValid;
   logic                      busy;

   // consumer and memory side
   modport master (
      output loadEnable, loadAddr, loadLen, memReadData,
      input  memReadEnable, memReadAddr, loadedBiases, loadValid, busy
   );

   // loader side
   modport slave (
      input  loadEnable, loadAddr, loadLen, memReadData,
      output memReadEnable, memReadAddr, loadedBiases, loadValid, busy
   );
endinterface

// File: rtl/bias_block_loader.sv
// rtl/bias_block_loader.sv - fetches a block of signed bias words from memory into a register array
module bias_block_loader #(
   parameter int DATA_SZ   = 16,
   parameter int ADDR_SZ   = 16,
   parameter int BLOCK_LEN = 25
) (
   input  logic              clk,
   input  logic              reset,
   bias_block_loader_if.slave bus
);
   localparam int CNT_W = $clog2(BLOCK_LEN + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   logic [1:0]         state;
   logic [ADDR_SZ-1:0] base_addr;
   logic [CNT_W-1:0]   eff_len;
   logic [CNT_W-1:0]   issue_cnt;
   logic [CNT_W-1:0]   pend_idx;
   logic               pend_valid;
   logic [CNT_W-1:0]   req_len;

   // a zero or oversized request length means a full block
   always_comb begin
      req_len = CNT_W'(BLOCK_LEN);
      if (bus.loadLen != 5'd0 && 32'(bus.loadLen) <= BLOCK_LEN)
         req_len = CNT_W'(bus.loadLen);
   end

   assign bus.busy = (state != IDLE);

   // request sequencing: issue reads, track the one in flight, handshake the result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         base_addr         <= '0;
         eff_len           <= '0;
         issue_cnt         <= '0;
         pend_idx          <= '0;
         pend_valid        <= 1'b0;
         bus.memReadEnable <= 1'b0;
         bus.memReadAddr   <= '0;
         bus.loadValid     <= 1'b0;
      end else begin
         // the memory registers the strobe, so data for the offset presented
         // now is on memReadData one edge later and captured the edge after
         pend_valid <= bus.memReadEnable;
         pend_idx   <= issue_cnt - CNT_W'(1);

         case (state)
            IDLE: begin
               if (bus.loadEnable) begin
                  base_addr         <= bus.loadAddr;
                  eff_len           <= req_len;
                  bus.memReadAddr   <= bus.loadAddr;
                  bus.memReadEnable <= 1'b1;
                  issue_cnt         <= CNT_W'(1);
                  state             <= READ;
               end
            end
            READ: begin
               if (issue_cnt == eff_len) begin
                  bus.memReadEnable <= 1'b0;
                  state             <= DRAIN;
               end else begin
                  // address wraps naturally at the top of the address space
                  bus.memReadAddr <= base_addr + ADDR_SZ'(issue_cnt);
                  issue_cnt       <= issue_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (pend_valid && pend_idx == eff_len - CNT_W'(1)) begin
                  bus.loadValid <= 1'b1;
                  state         <= HOLD;
               end
            end
            HOLD: begin
               if (!bus.loadEnable) begin
                  bus.loadValid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // block storage: clear the unused tail on acceptance, then fill from returning reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < BLOCK_LEN; k++)
            bus.loadedBiases[k] <= '0;
      end else if (state == IDLE && bus.loadEnable) begin
         for (int k = 0; k < BLOCK_LEN; k++)
            if (CNT_W'(k) >= req_len)
               bus.loadedBiases[k] <= '0;
      end else if (pend_valid) begin
         bus.loadedBiases[pend_idx] <= bus.memReadData;
      end
   end
endmodule

// File: tb/tb_bias_block_loader.sv
// tb/tb_bias_block_loader.sv - scoreboard bench for bias_block_loader with a behavioural memory
module tb_bias_block_loader;
   localparam int DATA_SZ   = 16;
   localparam int ADDR_SZ   = 16;
   localparam int BLOCK_LEN = 25;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;

   always #5 clk = ~clk;

   bias_block_loader_if #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ), .BLOCK_LEN(BLOCK_LEN)) bus ();

   bias_block_loader #(.DATA_SZ(DATA_SZ), .ADDR_SZ(ADDR_SZ), .BLOCK_LEN(BLOCK_LEN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // memory content: word at address a is a-112, so address 100+k holds k-12
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a - 16'd112;
   endfunction

   // cycle counter advances on the same edge the design samples
   always @(posedge clk) cyc <= cyc + 1;

   // registered-read memory: data follows one edge after the strobe is sampled
   always @(posedge clk)
      if (bus.memReadEnable)
         bus.memReadData <= mem_word(bus.memReadAddr);

   // scoreboard queues
   logic [15:0] exp_addr_q[$];
   logic [15:0] exp_bias_q[$];
   int          exp_rise_q[$];
   int          exp_fall_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int stall = 0;
   bit prev_valid = 1'b0;
   bit done = 1'b0;

   // monitor: compares every DUT output event against the queued expectations
   always @(negedge clk) begin : mon
      logic [15:0] e;
      int          ei;
      int          bad_idx;
      logic [15:0] bad_got;
      logic [15:0] bad_exp;
      if (reset) begin
         n_cmp++;
         bad_idx = -1;
         for (int k = 0; k < BLOCK_LEN; k++)
            if (bus.loadedBiases[k] !== 16'd0 && bad_idx < 0) bad_idx = k;
         if (bus.busy !== 1'b0 || bus.loadValid !== 1'b0 || bus.memReadEnable !== 1'b0 ||
             bus.memReadAddr !== 16'd0 || bad_idx >= 0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b valid=%b en=%b addr=%h first_nonzero_entry=%0d required all 0",
                     bus.busy, bus.loadValid, bus.memReadEnable, bus.memReadAddr, bad_idx);
         end
         stall = 0;
      end else begin
         if (bus.memReadEnable) begin
            n_cmp++;
            if (exp_addr_q.size() == 0) begin
               n_bad++;
               $display("FAIL strobe_unexpected: got addr %h required no strobe", bus.memReadAddr);
            end else begin
               e = exp_addr_q.pop_front();
               if (bus.memReadAddr !== e) begin
                  n_bad++;
                  $display("FAIL strobe_addr: got %h required %h", bus.memReadAddr, e);
               end
            end
         end
         if (bus.loadValid && !prev_valid) begin
            n_cmp++;
            if (exp_rise_q.size() == 0) begin
               n_bad++;
               $display("FAIL valid_unexpected: rose at cycle %0d required no rise", cyc);
            end else begin
               ei = exp_rise_q.pop_front();
               if (cyc != ei) begin
                  n_bad++;
                  $display("FAIL valid_latency: rose at cycle %0d required %0d", cyc, ei);
               end
            end
            n_cmp++;
            if (exp_addr_q.size() != 0) begin
               n_bad++;
               $display("FAIL strobe_count: %0d strobes missing required 0", exp_addr_q.size());
               exp_addr_q.delete();
            end
            n_cmp++;
            if (exp_bias_q.size() < BLOCK_LEN) begin
               n_bad++;
               $display("FAIL block_data: %0d expected entries queued required %0d", exp_bias_q.size(), BLOCK_LEN);
               exp_bias_q.delete();
            end else begin
               bad_idx = -1;
               bad_got = '0;
               bad_exp = '0;
               for (int k = 0; k < BLOCK_LEN; k++) begin
                  e = exp_bias_q.pop_front();
                  if (bus.loadedBiases[k] !== e && bad_idx < 0) begin
                     bad_idx = k;
                     bad_got = bus.loadedBiases[k];
                     bad_exp = e;
                  end
               end
               if (bad_idx >= 0) begin
                  n_bad++;
                  $display("FAIL block_data: entry %0d got %0d required %0d",
                           bad_idx, $signed(bad_got), $signed(bad_exp));
               end
            end
         end
         if (!bus.loadValid && prev_valid) begin
            n_cmp++;
            if (exp_fall_q.size() == 0) begin
               n_bad++;
               $display("FAIL valid_fall_unexpected: fell at cycle %0d required no fall", cyc);
            end else begin
               ei = exp_fall_q.pop_front();
               if (cyc != ei || bus.busy !== 1'b0) begin
                  n_bad++;
                  $display("FAIL valid_fall: fell at cycle %0d busy=%b required cycle %0d busy=0",
                           cyc, bus.busy, ei);
               end
            end
         end
         if (bus.loadEnable && !bus.loadValid) stall++;
         else stall = 0;
         if (stall == 80) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall: request pending %0d cycles required loadValid within 27", stall);
         end
      end
      prev_valid = bus.loadValid;
      if (done) begin
         n_cmp++;
         if (exp_addr_q.size() + exp_bias_q.size() + exp_rise_q.size() + exp_fall_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d/%0d/%0d/%0d expectations unmet required 0",
                     exp_addr_q.size(), exp_bias_q.size(), exp_rise_q.size(), exp_fall_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

   // reference model: push what a request must produce, then present it
   task automatic issue_request(input logic [15:0] a, input logic [4:0] l);
      int          eff;
      logic [15:0] ad;
      eff = (l == 5'd0 || l > 5'd25) ? 25 : int'(l);
      for (int k = 0; k < eff; k++) begin
         ad = a + 16'(k);
         exp_addr_q.push_back(ad);
      end
      for (int k = 0; k < BLOCK_LEN; k++) begin
         ad = a + 16'(k);
         exp_bias_q.push_back(k < eff ? mem_word(ad) : 16'd0);
      end
      exp_rise_q.push_back(cyc + 1 + eff + 1);
      bus.loadEnable = 1'b1;
      bus.loadAddr   = a;
      bus.loadLen    = l;
      @(negedge clk);
      // request fields must be ignored once sampled
      bus.loadAddr = 16'($urandom);
      bus.loadLen  = 5'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((bus.busy || bus.loadValid) && t < 100) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic run_load(input logic [15:0] a, input logic [4:0] l, input int hold, input bit toggle);
      int t;
      wait_idle();
      issue_request(a, l);
      if (toggle) begin
         @(negedge clk);
         bus.loadEnable = 1'b0;
         repeat (2) @(negedge clk);
         bus.loadEnable = 1'b1;
      end
      t = 0;
      while (!bus.loadValid && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (hold) @(negedge clk);
      bus.loadEnable = 1'b0;
      exp_fall_q.push_back(cyc + 1);
      @(negedge clk);
   endtask

   task automatic reset_mid_load();
      wait_idle();
      issue_request(16'h0300, 5'd0);
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      bus.loadEnable = 1'b0;
      exp_addr_q.delete();
      exp_bias_q.delete();
      exp_rise_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // stimulus: directed corner cases, then randomized requests
   initial begin
      logic [4:0]  l;
      logic [15:0] a;
      int          eff;
      bus.loadEnable = 1'b0;
      bus.loadAddr   = '0;
      bus.loadLen    = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_load(16'd100, 5'd0, 0, 1'b0);
      run_load(16'd40, 5'd3, 1, 1'b0);
      run_load(16'hFFF0, 5'd25, 2, 1'b0);
      reset_mid_load();
      run_load(16'd100, 5'd0, 0, 1'b0);
      run_load(16'd1234, 5'd10, 5, 1'b0);
      run_load(16'd500, 5'd20, 0, 1'b1);
      run_load(16'd7, 5'd31, 1, 1'b0);
      run_load(16'hFFFF, 5'd1, 0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         l = 5'($urandom_range(0, 31));
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFE0, 16'hFFFF)) : 16'($urandom);
         eff = (l == 5'd0 || l > 5'd25) ? 25 : int'(l);
         run_load(a, l, $urandom_range(0, 4), (eff >= 6) && ($urandom_range(0, 1) == 1));
      end
      repeat (3) @(negedge clk);
      done = 1'b1;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not reach summary");
      $fatal(1);
   end
endmodule
